// File: rtl/alu_top.sv
// rtl/alu_top.sv - button-loaded operand/opcode registers driving a combinational ALU onto the LEDs
module alu_top #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
) (
    input  logic              i_clock,
    input  logic              i_rst_n,
    input  logic [N_BITS-1:0] data_bus,
    input  logic              bt_1,
    input  logic              bt_2,
    input  logic              bt_3,
    output logic [N_BITS-1:0] leds
);

    localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
    localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);

    // N_BITS >= N_OP >= 6 guarantees N_BITS itself fits in an operand-wide value.
    localparam logic [N_BITS-1:0] SHIFT_LIMIT = N_BITS[N_BITS-1:0];

    logic [N_BITS-1:0] reg_a;
    logic [N_BITS-1:0] reg_b;
    logic [N_OP-1:0]   reg_op;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (bt_1) reg_a  <= data_bus;
            if (bt_2) reg_b  <= data_bus;
            if (bt_3) reg_op <= data_bus[N_OP-1:0];
        end
    end

    logic              shift_over;
    logic [N_BITS-1:0] sign_fill;
    logic [N_BITS-1:0] sra_result;
    logic [N_BITS-1:0] srl_result;

    // Oversized shift amounts are clamped explicitly rather than left to operator semantics.
    always_comb begin
        shift_over = (reg_b >= SHIFT_LIMIT);
        sign_fill  = {N_BITS{reg_a[N_BITS-1]}};
        if (shift_over) begin
            sra_result = sign_fill;
            srl_result = '0;
        end else begin
            sra_result = unsigned'($signed(reg_a) >>> reg_b);
            srl_result = reg_a >> reg_b;
        end
    end

    always_comb begin
        leds = '0;
        case (reg_op)
            OP_ADD:  leds = reg_a + reg_b;
            OP_SUB:  leds = reg_a - reg_b;
            OP_AND:  leds = reg_a & reg_b;
            OP_OR:   leds = reg_a | reg_b;
            OP_XOR:  leds = reg_a ^ reg_b;
            OP_NOR:  leds = ~(reg_a | reg_b);
            OP_SRA:  leds = sra_result;
            OP_SRL:  leds = srl_result;
            default: leds = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_top.sv
// tb/tb_alu_top.sv - table-driven self-checking bench for alu_top
module tb_alu_top;

    logic       i_clock = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] data_bus = 8'h00;
    logic       bt_1 = 1'b0;
    logic       bt_2 = 1'b0;
    logic       bt_3 = 1'b0;
    logic [7:0] leds;

    int errors = 0;
    int checks = 0;

    alu_top #(.N_BITS(8), .N_OP(6)) dut (
        .i_clock (i_clock),
        .i_rst_n (i_rst_n),
        .data_bus(data_bus),
        .bt_1    (bt_1),
        .bt_2    (bt_2),
        .bt_3    (bt_3),
        .leds    (leds)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: leds=%02h expected=%02h", name, act, exp);
        end
    endtask

    // Drive after a falling edge, hold across one rising edge, release at the next falling edge.
    task automatic press(input logic [2:0] btns, input logic [7:0] value);
        @(negedge i_clock);
        data_bus = value;
        {bt_3, bt_2, bt_1} = btns;
        @(negedge i_clock);
        {bt_3, bt_2, bt_1} = 3'b000;
        #1;
    endtask

    initial begin
        vecs.push_back('{"add_wrap",  8'hFF, 8'h02, 6'b100000, 8'h01});
        vecs.push_back('{"add_plain", 8'h23, 8'h14, 6'b100000, 8'h37});
        vecs.push_back('{"sub_neg",   8'h05, 8'h06, 6'b100010, 8'hFF});
        vecs.push_back('{"and",       8'hCA, 8'h0F, 6'b100100, 8'h0A});
        vecs.push_back('{"or",        8'hCA, 8'h0F, 6'b100101, 8'hCF});
        vecs.push_back('{"xor",       8'hCA, 8'h0F, 6'b100110, 8'hC5});
        vecs.push_back('{"nor",       8'hCA, 8'h0F, 6'b100111, 8'h30});
        vecs.push_back('{"sra_2",     8'h80, 8'h02, 6'b000011, 8'hE0});
        vecs.push_back('{"srl_2",     8'h80, 8'h02, 6'b000010, 8'h20});
        vecs.push_back('{"srl_9",     8'h80, 8'h09, 6'b000010, 8'h00});
        vecs.push_back('{"srl_8",     8'hFF, 8'h08, 6'b000010, 8'h00});
        vecs.push_back('{"srl_7",     8'h80, 8'h07, 6'b000010, 8'h01});
        vecs.push_back('{"sra_7",     8'h80, 8'h07, 6'b000011, 8'hFF});
        vecs.push_back('{"sra_9",     8'h80, 8'h09, 6'b000011, 8'hFF});
        vecs.push_back('{"sra_pos",   8'h40, 8'h01, 6'b000011, 8'h20});
        vecs.push_back('{"sra_pos_big", 8'h7F, 8'hC8, 6'b000011, 8'h00});
        vecs.push_back('{"invalid_3f", 8'h12, 8'h34, 6'b111111, 8'h00});
        vecs.push_back('{"invalid_00", 8'h12, 8'h34, 6'b000000, 8'h00});

        // Reset and release with no buttons.
        #3;
        check("reset_asserted", leds, 8'h00);
        @(negedge i_clock);
        i_rst_n = 1'b1;
        @(negedge i_clock);
        #1;
        check("reset_released_idle", leds, 8'h00);

        // 1 + 1 loaded one button at a time.
        press(3'b001, 8'h01);
        press(3'b010, 8'h01);
        check("op0_still_zero", leds, 8'h00);
        press(3'b100, 8'h20);
        check("add_1_1", leds, 8'h02);

        // SUB, then reload A; result moves on the edge that captures A.
        press(3'b001, 8'd35);
        press(3'b010, 8'd20);
        press(3'b100, 8'h22);
        check("sub_35_20", leds, 8'h0F);
        @(negedge i_clock);
        data_bus = 8'd100;
        bt_1 = 1'b1;
        #1;
        check("sub_before_edge", leds, 8'h0F);
        @(posedge i_clock);
        #1;
        check("sub_after_load_a", leds, 8'h50);
        bt_1 = 1'b0;

        // No button: registers hold even as the bus changes.
        data_bus = 8'hAA;
        repeat (3) @(posedge i_clock);
        #1;
        check("hold_no_button", leds, 8'h50);

        // Held button reloads each cycle.
        @(negedge i_clock);
        bt_2 = 1'b1;
        data_bus = 8'd10;
        @(negedge i_clock);
        #1;
        check("held_b_first", leds, 8'h5A);
        data_bus = 8'd30;
        @(negedge i_clock);
        #1;
        check("held_b_second", leds, 8'h46);
        bt_2 = 1'b0;

        foreach (vecs[i]) begin
            press(3'b001, vecs[i].a);
            press(3'b010, vecs[i].b);
            press(3'b100, {2'b11, vecs[i].op});
            check(vecs[i].name, leds, vecs[i].exp);
        end

        // Upper bus bits ignored on opcode load: 0xE0 -> ADD.
        press(3'b001, 8'h30);
        press(3'b010, 8'h05);
        press(3'b100, 8'hE0);
        check("op_upper_ignored", leds, 8'h35);

        // All three buttons together: A=B=0x22, op=SUB.
        press(3'b111, 8'h22);
        check("all_buttons_sub", leds, 8'h00);
        press(3'b100, 8'h20);
        check("all_buttons_add", leds, 8'h44);

        // Asynchronous reset between edges, with buttons held.
        @(posedge i_clock);
        #2;
        data_bus = 8'h20;
        {bt_3, bt_2, bt_1} = 3'b111;
        i_rst_n = 1'b0;
        #1;
        check("async_reset_immediate", leds, 8'h00);
        @(posedge i_clock);
        #1;
        check("reset_overrides_buttons", leds, 8'h00);
        @(negedge i_clock);
        i_rst_n = 1'b1;
        @(posedge i_clock);
        #1;
        check("load_after_release", leds, 8'h40);
        {bt_3, bt_2, bt_1} = 3'b000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
